// File: rtl/wu_memory_read_port_pkg.sv
// wu_memory_read_port_pkg: shared WU memory constants and controller state encodings.
package wu_memory_read_port_pkg;
  localparam int MGR_WU_ADDRESS_RANGE = 10;
  localparam int WUM_DEF_DATA_WIDTH   = 64;
  localparam int WUM_DEF_RD_LATENCY   = 2;
  localparam int WUM_DEF_FIFO_DEPTH   = 8;
  localparam int WUM_DEF_SKID         = 4;
  localparam int WUM_CNTL_STATE_RANGE = 2;
  typedef enum logic [WUM_CNTL_STATE_RANGE-1:0] {
    WUM_RUN   = 2'd0,
    WUM_STALL = 2'd1,
    WUM_ERR   = 2'd2
  } wum_cntl_state_e;
endpackage

// File: rtl/wum_out_fifo.sv
// wum_out_fifo: synchronous FIFO with occupancy count; a push into a full FIFO is dropped unless a pop frees the slot that cycle.
module wum_out_fifo #(
  parameter int W     = 74,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          i_reset_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  logic w_wr, w_rd;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_rd    = i_pop & ~o_empty;
  assign w_wr    = i_push & (~o_full | w_rd);
  assign o_rdata = r_mem[r_rp];
  assign o_count = r_count;
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_wdata;
  end
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end
endmodule

// File: rtl/wu_memory_read_port.sv
// wu_memory_read_port: WU instruction store, latency-matched read pipe, in-order output FIFO and early stall.
// Define WUM_PARITY_EN to store an even-parity bit per word and flag mismatches at pipe exit.
module wu_memory_read_port
  import wu_memory_read_port_pkg::*;
#(
  parameter int ADDR_WIDTH = MGR_WU_ADDRESS_RANGE,
  parameter int DATA_WIDTH = WUM_DEF_DATA_WIDTH,
  parameter int RD_LATENCY = WUM_DEF_RD_LATENCY,
  parameter int FIFO_DEPTH = WUM_DEF_FIFO_DEPTH,
  parameter int SKID       = WUM_DEF_SKID
) (
  input  logic                  clk,
  input  logic                  reset_poweron,
  input  logic                  wuf__wum__read,
  input  logic [ADDR_WIDTH-1:0] wuf__wum__addr,
  output logic                  wum__wuf__stall,
  input  logic                  sys__wum__write,
  input  logic [ADDR_WIDTH-1:0] sys__wum__addr,
  input  logic [DATA_WIDTH-1:0] sys__wum__wdata,
  output logic                  wum__wud__valid,
  output logic [DATA_WIDTH-1:0] wum__wud__data,
  output logic [ADDR_WIDTH-1:0] wum__wud__addr,
  input  logic                  wud__wum__ready,
  output logic                  wum__mcntl__error
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(FIFO_DEPTH + RD_LATENCY + SKID + 1) + 1;
  localparam int FW = ADDR_WIDTH + DATA_WIDTH;
`ifdef WUM_PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif
  logic [MW-1:0] r_mem [2**ADDR_WIDTH];
  logic [RD_LATENCY-1:0] r_pv;
  logic [MW-1:0] r_pd [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] r_pa [RD_LATENCY];
  logic [FW-1:0] r_hold;
  wum_cntl_state_e r_state, w_next;
  logic r_stall, r_error;
  logic [MW-1:0] w_wword;
  logic w_push, w_pop, w_full, w_empty, w_overflow, w_par_err, w_stall_e1;
  logic [FW-1:0] w_head;
  logic [CW-1:0] w_count;
  logic [OW-1:0] w_inflight, w_occ;
`ifdef WUM_PARITY_EN
  assign w_wword   = {^sys__wum__wdata, sys__wum__wdata};
  assign w_par_err = w_push & (^r_pd[RD_LATENCY-1]);
`else
  assign w_wword   = sys__wum__wdata;
  assign w_par_err = 1'b0;
`endif
  // Storage read is registered, so a same-cycle write to the read address yields the old word.
  always_ff @(posedge clk) begin
    if (sys__wum__write) r_mem[sys__wum__addr] <= w_wword;
    r_pd[0] <= r_mem[wuf__wum__addr];
    r_pa[0] <= wuf__wum__addr;
    for (int i = 1; i < RD_LATENCY; i++) begin
      r_pd[i] <= r_pd[i-1];
      r_pa[i] <= r_pa[i-1];
    end
  end
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) w_inflight = w_inflight + OW'(r_pv[i]);
  end
  assign w_push     = r_pv[RD_LATENCY-1];
  assign w_pop      = ~w_empty & wud__wum__ready;
  assign w_overflow = w_push & w_full & ~w_pop;
  assign w_occ      = OW'(w_count) + w_inflight;
  assign w_stall_e1 = (w_occ + OW'(SKID)) >= OW'(FIFO_DEPTH);
  always_comb begin
    w_next = (r_state == WUM_ERR || w_overflow || w_par_err) ? WUM_ERR :
             w_stall_e1 ? WUM_STALL : WUM_RUN;
  end
  always_ff @(posedge clk) begin
    if (!reset_poweron) begin
      r_pv    <= '0;
      r_state <= WUM_RUN;
      r_stall <= 1'b0;
      r_error <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_pv[0] <= wuf__wum__read;
      for (int i = 1; i < RD_LATENCY; i++) r_pv[i] <= r_pv[i-1];
      r_state <= w_next;
      r_stall <= (w_next != WUM_RUN);
      r_error <= (w_next == WUM_ERR);
      if (w_pop) r_hold <= w_head;
    end
  end
  wum_out_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .i_reset_n (reset_poweron),
    .i_push    (w_push),
    .i_wdata   ({r_pa[RD_LATENCY-1], r_pd[RD_LATENCY-1][DATA_WIDTH-1:0]}),
    .i_pop     (w_pop),
    .o_rdata   (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );
  // The last popped word stays on the output while the FIFO is empty.
  assign {wum__wud__addr, wum__wud__data} = w_empty ? r_hold : w_head;
  assign wum__wud__valid   = ~w_empty;
  assign wum__wuf__stall   = r_stall;
  assign wum__mcntl__error = r_error;
endmodule

// File: tb/tb_wu_memory_read_port.sv
// tb_wu_memory_read_port: randomized and directed checks against a queue-based model of the read port.
module tb_wu_memory_read_port;
  localparam int AW  = 10;
  localparam int DW  = 64;
  localparam int L   = 2;
  localparam int D   = 8;
  localparam int SK  = 4;
  localparam int OBW = 3 + AW + DW;
  logic clk = 1'b0;
  logic rst_n, rd, wr, rdy;
  logic [AW-1:0] raddr, waddr, oaddr;
  logic [DW-1:0] wdata, odata;
  logic stall, valid, err;
  logic [OBW-1:0] obs;
  always #5 clk = ~clk;
  wu_memory_read_port #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .RD_LATENCY (L), .FIFO_DEPTH (D), .SKID (SK)
  ) dut (
    .clk               (clk),
    .reset_poweron     (rst_n),
    .wuf__wum__read    (rd),
    .wuf__wum__addr    (raddr),
    .wum__wuf__stall   (stall),
    .sys__wum__write   (wr),
    .sys__wum__addr    (waddr),
    .sys__wum__wdata   (wdata),
    .wum__wud__valid   (valid),
    .wum__wud__data    (odata),
    .wum__wud__addr    (oaddr),
    .wud__wum__ready   (rdy),
    .wum__mcntl__error (err)
  );
  assign obs = {valid, stall, err, oaddr, odata};
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            bad;
    int            due;
  } ent_t;
  logic [DW-1:0] m_mem [1<<AW];
  bit m_bad [1<<AW];
  ent_t m_pipe[$];
  ent_t m_fifo[$];
  ent_t m_last;
  bit m_err, m_stall;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  // Model: each accepted read becomes a word that lands in the FIFO L edges later.
  task automatic tick();
    int e, occ;
    bit pop, push, ovf;
    ent_t ent;
    e = cyc + 1;
    occ = m_fifo.size() + m_pipe.size();
    if (!rst_n) begin
      m_pipe.delete();
      m_fifo.delete();
      m_err = 0;
      m_stall = 0;
      m_last = '{a: '0, d: '0, bad: 0, due: 0};
    end else begin
      pop  = m_fifo.size() > 0 && rdy;
      push = m_pipe.size() > 0 && m_pipe[0].due == e;
      ovf  = push && m_fifo.size() == D && !pop;
      if (pop) m_last = m_fifo.pop_front();
      if (push) begin
        ent = m_pipe.pop_front();
        if (!ovf) m_fifo.push_back(ent);
        m_err = m_err | ovf | ent.bad;
      end
      if (rd) begin
        ent = '{a: raddr, d: m_mem[raddr], bad: m_bad[raddr], due: e + L};
        m_pipe.push_back(ent);
      end
      m_stall = (occ + SK >= D) || m_err;
    end
    if (wr) begin
      m_mem[waddr] = wdata;
      m_bad[waddr] = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  function automatic logic [OBW-1:0] expv();
    ent_t h;
    h = m_last;
    if (m_fifo.size() > 0) h = m_fifo[0];
    return {m_fifo.size() > 0, m_stall, m_err, h.a, h.d};
  endfunction
  task automatic drain(input string nm, output int n);
    rd = 0; wr = 0; rdy = 1; n = 0;
    for (int k = 0; k < 64 && (m_fifo.size() > 0 || m_pipe.size() > 0 || valid); k++) begin
      if (valid) n++;
      tick();
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, obs, expv()); end
    end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL %s_timeout valid=%b exp=0", nm, valid); end
  endtask
  task automatic test_reset();
    rst_n = 0; rd = 0; wr = 0; rdy = 0; raddr = '0; waddr = '0; wdata = '0;
    tick(); tick();
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    rst_n = 1;
    tick();
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL reset_release got=%h exp=%h", obs, expv()); end
  endtask
  task automatic test_preload_read();
    int c0, first, n;
    for (int i = 0; i < 16; i++) begin
      wr = 1; waddr = AW'(i); wdata = DW'(i * 3);
      tick();
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL preload_wr cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
    end
    wr = 0; rdy = 1; c0 = cyc; first = -1; n = 0;
    for (int k = 0; k < 24; k++) begin
      rd = (k < 16); raddr = AW'(k);
      if (valid) begin
        if (first < 0) first = cyc;
        checks++;
        if (odata !== DW'(3 * n)) begin errors++; $display("FAIL preload_word n=%0d got=%0d exp=%0d", n, odata, 3 * n); end
        n++;
      end
      tick();
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL preload_rd cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
    end
    rd = 0;
    checks++;
    if (first - c0 != L + 1) begin errors++; $display("FAIL first_latency got=%0d exp=%0d", first - c0, L + 1); end
    checks++;
    if (n != 16) begin errors++; $display("FAIL preload_count got=%0d exp=16", n); end
  endtask
  task automatic test_same_cycle_rw();
    logic [DW-1:0] got [2];
    int n;
    rdy = 0; wr = 1; waddr = 5; wdata = 64'h55;
    tick();
    wdata = 64'hAA; rd = 1; raddr = 5;
    tick();
    wr = 0;
    tick();
    rd = 0; rdy = 1; n = 0;
    for (int k = 0; k < 10; k++) begin
      if (valid && n < 2) begin got[n] = odata; n++; end
      tick();
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL rw_flow cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
    end
    checks++;
    if (n != 2) begin errors++; $display("FAIL rw_count got=%0d exp=2", n); end
    checks++;
    if (got[0] !== 64'h55) begin errors++; $display("FAIL rw_old got=%h exp=55", got[0]); end
    checks++;
    if (got[1] !== 64'hAA) begin errors++; $display("FAIL rw_new got=%h exp=aa", got[1]); end
  endtask
  task automatic test_stall_flow();
    int c0, fs, s, n;
    rdy = 0; s = 0; fs = -1; c0 = cyc;
    for (int k = 0; k < 20; k++) begin
      if (stall) begin
        s++;
        if (fs < 0) fs = cyc;
      end
      rd = (s <= 3); raddr = AW'($urandom_range(0, 15));
      tick();
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL stall_flow cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
    end
    rd = 0;
    checks++;
    if (fs - c0 != D - SK + 1) begin errors++; $display("FAIL stall_rise got=%0d exp=%0d", fs - c0, D - SK + 1); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL stall_noerr got=%b exp=0", err); end
    drain("stall_drain", n);
    checks++;
    if (n != D) begin errors++; $display("FAIL stall_fill got=%0d exp=%0d", n, D); end
  endtask
  task automatic test_overflow();
    rdy = 0;
    for (int k = 0; k < 14; k++) begin
      rd = (k < 10); raddr = AW'($urandom_range(0, 15));
      tick();
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL ovf_flow cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
    end
    rd = 0;
    checks++;
    if ({err, stall} !== 2'b11) begin errors++; $display("FAIL ovf_err got=%b%b exp=11", err, stall); end
    rdy = 1;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL ovf_drain cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
    end
    checks++;
    if ({err, stall, valid} !== 3'b110) begin errors++; $display("FAIL ovf_sticky got=%b%b%b exp=110", err, stall, valid); end
    rst_n = 0;
    tick();
    rst_n = 1;
    checks++;
    if ({err, stall} !== 2'b00) begin errors++; $display("FAIL ovf_reset got=%b%b exp=00", err, stall); end
  endtask
  task automatic test_reset_midop();
    bit seen;
    rdy = 0;
    for (int k = 0; k < 6; k++) begin
      rd = 1; raddr = AW'(k);
      tick();
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL mid_flow cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
    end
    checks++;
    if ({valid, stall} !== 2'b11) begin errors++; $display("FAIL mid_pre got=%b%b exp=11", valid, stall); end
    rst_n = 0;
    tick();
    rst_n = 1;
    checks++;
    if ({valid, stall, err} !== 3'b000) begin errors++; $display("FAIL mid_reset got=%b%b%b exp=000", valid, stall, err); end
    rd = 1; raddr = 5;
    tick();
    rd = 0; rdy = 1; seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      if (valid) begin
        seen = 1;
        checks++;
        if ({oaddr, odata} !== {AW'(5), 64'hAA}) begin errors++; $display("FAIL mid_readback got=%h/%h exp=5/aa", oaddr, odata); end
      end
      tick();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mid_readback_timeout valid=0 exp=1"); end
  endtask
`ifdef WUM_PARITY_EN
  task automatic test_parity();
    bit seen;
    wr = 1; waddr = 7; wdata = {$urandom, $urandom};
    tick();
    wr = 0;
    dut.r_mem[7][0] = ~dut.r_mem[7][0];
    m_mem[7][0] = ~m_mem[7][0];
    m_bad[7] = 1;
    rd = 1; raddr = 7; rdy = 1;
    tick();
    rd = 0; seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (valid) seen = 1;
      tick();
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL parity_flow cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
    end
    checks++;
    if (!seen || err !== 1'b1) begin errors++; $display("FAIL parity_err seen=%b err=%b exp=1/1", seen, err); end
    wr = 1; waddr = 7; wdata = 64'd21;
    rst_n = 0;
    tick();
    rst_n = 1; wr = 0;
  endtask
`endif
  task automatic test_random();
    int n;
    for (int k = 0; k < 300; k++) begin
      rd = ($urandom_range(0, 3) != 0) && !stall;
      raddr = AW'($urandom_range(0, 15));
      wr = ($urandom_range(0, 4) == 0);
      waddr = AW'($urandom_range(0, 15));
      wdata = {$urandom, $urandom};
      rdy = ($urandom_range(0, 2) != 0);
      tick();
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
    end
    drain("random_drain", n);
  endtask
  initial begin
    int n;
    test_reset();
    test_preload_read();
    test_same_cycle_rw();
    drain("pre_stall_drain", n);
    test_stall_flow();
    test_overflow();
    test_reset_midop();
`ifdef WUM_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end
endmodule
